// File: rtl/pe_seq_controller_if.sv
// pe_seq_controller_if
//   Bundles the scheduler handshake (start/mod/proc_len/abort, done/err/busy,
//   mode_q) and the weight-fetch valid/ready address bus of the PE sequencer.
//
//   Modports:
//     master : the controller (drives weight_in_valid, weight_addr,
//              process_enable, mode_q, busy, done, err)
//     slave  : scheduler / weight-memory side (drives mod, start, proc_len,
//              abort, weight_ready)
interface pe_seq_controller_if #(
  parameter int ADDR_W = 4,
  parameter int N_MODE = 3,
  parameter int CNT_W  = 8
);
  logic [N_MODE-1:0] mod;
  logic              start;
  logic [CNT_W-1:0]  proc_len;
  logic              abort;
  logic              weight_ready;
  logic              weight_in_valid;
  logic [ADDR_W-1:0] weight_addr;
  logic              process_enable;
  logic [N_MODE-1:0] mode_q;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  mod, start, proc_len, abort, weight_ready,
    output weight_in_valid, weight_addr, process_enable, mode_q, busy, done, err
  );

  modport slave (
    output mod, start, proc_len, abort, weight_ready,
    input  weight_in_valid, weight_addr, process_enable, mode_q, busy, done, err
  );
endinterface

// File: rtl/pe_seq_controller.sv
// pe_seq_controller
//   Sequences a processing element through a weight-load phase (valid/ready
//   address fetch, depth chosen by a one-hot mode) followed by a programmable
//   number of compute cycles, then a one-cycle done pulse.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : pe_seq_controller_if.master
//            in : mod (one-hot depth select), start, proc_len, abort,
//                 weight_ready
//            out: weight_in_valid, weight_addr, process_enable, mode_q,
//                 busy, done, err
//
//   All outputs are Moore: decoded from registered state or registers.
//   Mode bit k loads (2^ADDR_W)>>k weights; requires N_MODE <= ADDR_W+1.
module pe_seq_controller #(
  parameter int ADDR_W = 4,
  parameter int N_MODE = 3,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_seq_controller_if.master  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, PROC, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [N_MODE-1:0] mode_q, mode_nxt;
  logic [CNT_W-1:0]  len_q, len_nxt;
  logic [CNT_W-1:0]  pcnt, pcnt_nxt;
  logic              err_q, err_nxt;

  logic              mod_onehot;
  logic              fire;
  logic [ADDR_W-1:0] last;

  assign mod_onehot = $onehot(bus.mod);
  assign fire       = (state == LOAD) && bus.weight_ready;

  // Final address of the load phase for the latched mode. mode_q is always
  // one-hot once a pass has been accepted, so at most one term applies.
  always_comb begin
    last = '0;
    for (int k = 0; k < N_MODE; k++) begin
      if (mode_q[k]) last = ADDR_W'((DEPTH >> k) - 1);
    end
  end

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    mode_nxt  = mode_q;
    len_nxt   = len_q;
    pcnt_nxt  = pcnt;
    err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        // abort outranks start while idle: the request is dropped silently.
        if (bus.start && !bus.abort) begin
          if (mod_onehot) begin
            mode_nxt  = bus.mod;
            len_nxt   = bus.proc_len;
            addr_nxt  = '0;
            state_nxt = LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      LOAD: begin
        // Address only moves on an accepted beat, so it is stable while the
        // memory stalls, and it never passes the last address of the mode.
        if (fire) begin
          if (addr == last) begin
            addr_nxt = '0;
            pcnt_nxt = '0;
            state_nxt = (len_q == '0) ? DONE : PROC;
          end else begin
            addr_nxt = addr + ADDR_W'(1);
          end
        end
      end

      PROC: begin
        pcnt_nxt = pcnt + CNT_W'(1);
        // len_q is non-zero here (zero length bypasses PROC entirely).
        if (pcnt == len_q - CNT_W'(1)) begin
          pcnt_nxt  = '0;
          state_nxt = DONE;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && bus.abort) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      pcnt_nxt  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      mode_q <= '0;
      len_q  <= '0;
      pcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      mode_q <= mode_nxt;
      len_q  <= len_nxt;
      pcnt   <= pcnt_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.weight_in_valid = (state == LOAD);
  assign bus.weight_addr     = addr;
  assign bus.process_enable  = (state == PROC);
  assign bus.mode_q          = mode_q;
  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.err             = err_q;

endmodule

// File: tb/tb_pe_seq_controller.sv
// tb_pe_seq_controller
//   Self-checking bench for pe_seq_controller. For each pass the expected
//   per-cycle output trace is built up front from the pass parameters and the
//   weight_ready pattern (one LOAD cycle per ready sample, one address per
//   accepted beat, len PROC cycles, one DONE cycle), then the DUT is run and
//   compared cycle by cycle. Inputs are driven and outputs sampled on the
//   falling edge.
module tb_pe_seq_controller;

  localparam int ADDR_W = 4;
  localparam int N_MODE = 3;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              pe;
    logic              busy;
    logic              done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_seq_controller_if #(.ADDR_W(ADDR_W), .N_MODE(N_MODE), .CNT_W(CNT_W)) bus ();

  pe_seq_controller #(.ADDR_W(ADDR_W), .N_MODE(N_MODE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [N_MODE-1:0] exp_mode_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input int a, input logic pe, input logic b, input logic d);
    exp_t e;
    e.valid = v;
    e.addr  = a[ADDR_W-1:0];
    e.pe    = pe;
    e.busy  = b;
    e.done  = d;
    return e;
  endfunction

  function automatic int depth_of(input logic [N_MODE-1:0] m);
    for (int k = 0; k < N_MODE; k++) if (m[k]) return DEPTH >> k;
    return 0;
  endfunction

  task automatic check_outputs(input string ctx, input exp_t e);
    check({ctx, ".valid"}, 32'(bus.weight_in_valid), 32'(e.valid));
    check({ctx, ".addr"},  32'(bus.weight_addr),     32'(e.addr));
    check({ctx, ".pe"},    32'(bus.process_enable),  32'(e.pe));
    check({ctx, ".busy"},  32'(bus.busy),            32'(e.busy));
    check({ctx, ".done"},  32'(bus.done),            32'(e.done));
    check({ctx, ".mode_q"}, 32'(bus.mode_q),         32'(exp_mode_q));
    check({ctx, ".err"},   32'(bus.err),             32'(0));
  endtask

  // rdy_mode: 0 = ready always high, 1 = random, 2 = pattern 1,0,0,1,0,0,...
  task automatic run_pass(input string name, input logic [N_MODE-1:0] m,
                          input logic [CNT_W-1:0] len, input int rdy_mode,
                          input int abort_at, input bit noisy_start);
    exp_t trace[$];
    bit   rdy[$];
    int   depth    = depth_of(m);
    int   c        = 0;
    int   load_cyc = -1;
    int   done_cyc = -1;

    for (int a = 0; a < depth; a++) begin
      bit r;
      do begin
        case (rdy_mode)
          0:       r = 1'b1;
          1:       r = ($urandom_range(0, 2) != 0);
          default: r = (c % 3 == 0);
        endcase
        rdy.push_back(r);
        trace.push_back(mk(1'b1, a, 1'b0, 1'b1, 1'b0));
        c++;
      end while (!r);
    end
    for (int p = 0; p < int'(len); p++) begin
      trace.push_back(mk(1'b0, 0, 1'b1, 1'b1, 1'b0));
      rdy.push_back(1'($urandom_range(0, 1)));
    end
    trace.push_back(mk(1'b0, 0, 1'b0, 1'b1, 1'b1));
    rdy.push_back(1'b0);
    trace.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
    rdy.push_back(1'b0);

    // Abort only lands in LOAD/PROC: the pass is cut and IDLE follows.
    if (abort_at >= trace.size() - 2) abort_at = -1;
    if (abort_at >= 0) begin
      while (trace.size() > abort_at + 1) void'(trace.pop_back());
      trace.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
      trace.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b0));
    end

    @(negedge clk);
    bus.start        = 1'b1;
    bus.mod          = m;
    bus.proc_len     = len;
    bus.abort        = 1'b0;
    bus.weight_ready = 1'($urandom_range(0, 1));
    exp_mode_q       = m;

    foreach (trace[i]) begin
      @(negedge clk);
      check_outputs($sformatf("%s[%0d]", name, i), trace[i]);
      if (bus.weight_in_valid && load_cyc < 0) load_cyc = i;
      if (bus.done && done_cyc < 0) done_cyc = i;
      bus.weight_ready = rdy[i];
      bus.abort        = (i == abort_at);
      if (noisy_start && trace[i].busy) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.mod      = N_MODE'($urandom);
        bus.proc_len = CNT_W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;

    if (abort_at < 0 && rdy_mode == 0)
      check({name, ".latency"}, 32'(done_cyc - load_cyc + 1), 32'(depth + int'(len) + 1));
    if (abort_at >= 0)
      check({name, ".no_done"}, 32'(done_cyc), 32'(-1));
  endtask

  task automatic bad_start(input string name, input logic [N_MODE-1:0] m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mod   = m;
    @(negedge clk);
    check({name, ".err"},    32'(bus.err),    32'(1));
    check({name, ".busy"},   32'(bus.busy),   32'(0));
    check({name, ".valid"},  32'(bus.weight_in_valid), 32'(0));
    check({name, ".mode_q"}, 32'(bus.mode_q), 32'(exp_mode_q));
    bus.start = 1'b0;
    @(negedge clk);
    check({name, ".err_clr"}, 32'(bus.err),  32'(0));
    check({name, ".idle"},    32'(bus.busy), 32'(0));
  endtask

  task automatic abort_start_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.mod   = (exp_mode_q == 3'b001) ? 3'b010 : 3'b001;
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_idle.busy",   32'(bus.busy),   32'(0));
    check("abort_idle.err",    32'(bus.err),    32'(0));
    check("abort_idle.mode_q", 32'(bus.mode_q), 32'(exp_mode_q));
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    bus.start        = 1'b1;
    bus.mod          = 3'b001;
    bus.proc_len     = 8'd5;
    bus.weight_ready = 1'b1;
    exp_mode_q       = 3'b001;
    // start stays high throughout LOAD and must be ignored.
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("rst_load.addr%0d", i), 32'(bus.weight_addr), 32'(i));
      check($sformatf("rst_load.valid%0d", i), 32'(bus.weight_in_valid), 32'(1));
      bus.mod = N_MODE'($urandom);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_async.valid",  32'(bus.weight_in_valid), 32'(0));
    check("rst_async.addr",   32'(bus.weight_addr),     32'(0));
    check("rst_async.pe",     32'(bus.process_enable),  32'(0));
    check("rst_async.busy",   32'(bus.busy),            32'(0));
    check("rst_async.done",   32'(bus.done),            32'(0));
    check("rst_async.mode_q", 32'(bus.mode_q),          32'(0));
    bus.start  = 1'b0;
    exp_mode_q = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after.busy", 32'(bus.busy), 32'(0));
    check("rst_after.done", 32'(bus.done), 32'(0));
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.mod          = '0;
    bus.proc_len     = '0;
    bus.abort        = 1'b0;
    bus.weight_ready = 1'b0;
    exp_mode_q       = '0;
    #1;
    check("reset.valid",  32'(bus.weight_in_valid), 32'(0));
    check("reset.addr",   32'(bus.weight_addr),     32'(0));
    check("reset.pe",     32'(bus.process_enable),  32'(0));
    check("reset.busy",   32'(bus.busy),            32'(0));
    check("reset.done",   32'(bus.done),            32'(0));
    check("reset.err",    32'(bus.err),             32'(0));
    check("reset.mode_q", 32'(bus.mode_q),          32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_pass("full16_len5", 3'b001, 8'd5, 0, -1, 1'b0);
    run_pass("depth4_len0", 3'b100, 8'd0, 0, -1, 1'b0);
    run_pass("depth8_stall", 3'b010, 8'd7, 2, -1, 1'b0);
    bad_start("bad_011", 3'b011);
    bad_start("bad_000", 3'b000);
    // 16 LOAD cycles with ready high, abort during the third PROC cycle.
    run_pass("abort_proc", 3'b001, 8'd10, 0, 18, 1'b0);
    run_pass("after_abort", 3'b001, 8'd3, 0, -1, 1'b1);
    abort_start_idle();
    reset_mid_load();

    for (int p = 0; p < 20; p++) begin
      logic [N_MODE-1:0] m;
      logic [CNT_W-1:0]  len;
      int                ab;
      m   = N_MODE'(1) << $urandom_range(0, N_MODE - 1);
      len = CNT_W'($urandom_range(0, 12));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, depth_of(m) + int'(len))) : -1;
      run_pass($sformatf("rnd%0d", p), m, len, ($urandom_range(0, 1) == 0) ? 0 : 1, ab, 1'b1);
      if ($urandom_range(0, 3) == 0) bad_start($sformatf("rnd_bad%0d", p), 3'b110);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_seq_controller.md
Name: pe_seq_controller

Overview:
Parametrised successor to the PE controller. It sequences a processing element through weight loading and then processing. Weight-load depth is selected by a one-hot mode. The weight-fetch path uses a valid/ready handshake, processing length is programmable, and start/done/abort handshakes connect the block to the top-level scheduler.

Parameters:
ADDR_W, 4, weight address width; full weight depth = 2^ADDR_W
N_MODE, 3, number of one-hot mode bits; mode k loads (2^ADDR_W)>>k weights (requires N_MODE <= ADDR_W+1)
CNT_W, 8, width of process-length counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
mod  in  N_MODE  one-hot mode select, sampled only on accepted start
start  in  1  request a load+process pass, honoured in IDLE only
proc_len  in  CNT_W  number of process_enable cycles, sampled with start
abort  in  1  synchronous abort to IDLE
weight_ready  in  1  weight memory accepts current address
weight_in_valid  out  1  weight address valid
weight_addr  out  ADDR_W  current weight address
process_enable  out  1  PE compute enable
mode_q  out  N_MODE  latched mode, held until next accepted start
busy  out  1  high in LOAD/PROC/DONE
done  out  1  one-cycle pulse at pass completion
err  out  1  one-cycle pulse on start with non-one-hot mod

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0: weight_addr=0, mode_q=0; internal counters 0.
- All outputs are registered or decoded from registered state (Moore). No combinational path from inputs to outputs.
- FSM states: IDLE, LOAD, PROC, DONE.
- IDLE:
  - start=1 with mod one-hot: latch mode_q=mod, len_q=proc_len, addr=0; next LOAD.
  - start=1 with mod zero or multi-hot: stay IDLE; err=1 for the following cycle; mode_q unchanged.
- LOAD:
  - weight_in_valid=1; weight_addr=addr.
  - Handshake fires on valid&&ready. The address advances only on a fire; it is held stable while ready=0.
  - last = ((2^ADDR_W)>>k)-1 for the mode_q bit k.
  - Fire with addr==last: if len_q==0 go to DONE, else go to PROC with pcnt=0.
  - Fire with addr!=last: addr+1.
  - No wrap-around: the address never exceeds last.
- PROC:
  - process_enable=1; pcnt increments every cycle.
  - At pcnt==len_q-1 go to DONE. process_enable is high exactly len_q cycles.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle as the transition.
- Latency: start accepted at edge n gives weight_in_valid=1 after edge n. Total pass with ready tied high = depth + len_q + 1 cycles from LOAD entry to done.
- start outside IDLE is ignored. mod/proc_len changes after acceptance have no effect.
- abort=1 in any non-IDLE state:
  - Next state IDLE; no done pulse; weight_addr returns to 0; process_enable and weight_in_valid deassert next cycle.
  - abort in IDLE is a no-op.
  - abort and start together in IDLE: abort wins and start is ignored.
- Reset mid-operation: immediate return to reset values; no done pulse.
- weight_addr outside LOAD holds 0.

Test Plan:
- Reset then mod=3'b001, start 1 cycle, proc_len=5, ready=1 -> weight_addr 0..15 on consecutive cycles with valid=1; process_enable 5 cycles; done pulse 1 cycle; total 22 cycles LOAD->done.
- mod=3'b100, proc_len=0, ready=1 -> addresses 0..3 only, process_enable never high, done one cycle after addr 3 fires.
- mod=3'b010, ready toggled 1,0,0,1,... -> weight_addr holds value while ready=0; exactly 8 fires; addresses 0..7 in order.
- start with mod=3'b011, then mod=3'b000 -> err pulses each time, state stays IDLE, busy=0, mode_q unchanged.
- abort asserted at PROC cycle 2 of proc_len=10 -> process_enable low next cycle, no done, busy=0; a following start runs a full pass.
- rst asserted asynchronously mid-LOAD (addr=6) -> outputs 0 without waiting for a clock edge; start held high during LOAD has no effect.
